// File: rtl/fram_access_ctrl.sv
// -----------------------------------------------------------------------------
// fram_access_ctrl
//
// Front-end scheduler in front of the feature-RAM bank router. Reads are
// issued straight to the router read port when safe; writes are buffered in
// a small FIFO and drained through the router write port. Same-bank
// read/write collisions, read-after-write hazards against buffered writes
// and router data-mux bank switches are resolved here.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   rd_req_valid/ready/addr        read request stream (ready == issued now)
//   rd_rsp_valid/data              read response, exactly one cycle after issue
//   wr_req_valid/ready/addr/data   write request stream (ready == FIFO space)
//   rp_addr, rp_en, rp_rdata       router read port
//   wp_addr, wp_wdata, wp_we,wp_en router write port
//   idle                           write FIFO empty and no response pending
// -----------------------------------------------------------------------------
module fram_access_ctrl #(
    parameter int FRAM_ADDR_WIDTH = 12,
    parameter int DATA_WIDTH      = 32,
    parameter int BANK_NUM        = 4,
    parameter int WFIFO_DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic                       rd_req_valid,
    output logic                       rd_req_ready,
    input  logic [FRAM_ADDR_WIDTH-1:0] rd_req_addr,
    output logic                       rd_rsp_valid,
    output logic [DATA_WIDTH-1:0]      rd_rsp_data,

    input  logic                       wr_req_valid,
    output logic                       wr_req_ready,
    input  logic [FRAM_ADDR_WIDTH-1:0] wr_req_addr,
    input  logic [DATA_WIDTH-1:0]      wr_req_data,

    output logic [FRAM_ADDR_WIDTH-1:0] rp_addr,
    output logic                       rp_en,
    input  logic [DATA_WIDTH-1:0]      rp_rdata,

    output logic [FRAM_ADDR_WIDTH-1:0] wp_addr,
    output logic [DATA_WIDTH-1:0]      wp_wdata,
    output logic                       wp_we,
    output logic                       wp_en,

    output logic                       idle
);

    localparam int BANK_W = $clog2(BANK_NUM);
    localparam int PTR_W  = $clog2(WFIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [FRAM_ADDR_WIDTH-1:0] r_fifo_addr [WFIFO_DEPTH];
    logic [DATA_WIDTH-1:0]      r_fifo_data [WFIFO_DEPTH];
    logic [PTR_W-1:0]           r_wr_ptr;
    logic [PTR_W-1:0]           r_rd_ptr;
    logic [CNT_W-1:0]           r_count;
    logic                       r_rsp_pend;
    logic [FRAM_ADDR_WIDTH-1:0] r_last_rd_addr;

    // -------------------------------------------------------------------------
    // Combinational decode
    // -------------------------------------------------------------------------
    logic                       w_full;
    logic                       w_empty;
    logic                       w_push;
    logic                       w_pop;
    logic [FRAM_ADDR_WIDTH-1:0] w_head_addr;
    logic [DATA_WIDTH-1:0]      w_head_data;
    logic [BANK_W-1:0]          w_head_bank;
    logic [BANK_W-1:0]          w_rd_bank;
    logic [BANK_W-1:0]          w_last_bank;
    logic                       w_hazard;
    logic                       w_rd_ok;
    logic                       w_rd_issue;
    logic                       w_wr_issue;

    assign w_full      = (r_count == CNT_W'(WFIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_push      = wr_req_valid && !w_full;
    assign w_pop       = w_wr_issue;

    assign w_head_addr = r_fifo_addr[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];
    assign w_head_bank = w_head_addr[FRAM_ADDR_WIDTH-1 -: BANK_W];
    assign w_rd_bank   = rd_req_addr[FRAM_ADDR_WIDTH-1 -: BANK_W];
    assign w_last_bank = r_last_rd_addr[FRAM_ADDR_WIDTH-1 -: BANK_W];

    // Compare the read address against every occupied FIFO slot. A slot is
    // occupied when its distance from the read pointer is below the count.
    // Writes pushed this cycle are younger than the read and are not checked.
    always_comb begin
        logic [PTR_W-1:0] v_off;
        w_hazard = 1'b0;
        v_off    = '0;
        for (int unsigned i = 0; i < WFIFO_DEPTH; i++) begin
            v_off = PTR_W'(i) - r_rd_ptr;
            if (({1'b0, v_off} < r_count) && (r_fifo_addr[i] == rd_req_addr)) begin
                w_hazard = 1'b1;
            end
        end
    end

    // While a response is in flight the router's data mux follows rp_addr,
    // so only a read to the same bank may issue; a bank switch costs one
    // bubble. rst_n gates the read so no request is accepted during reset.
    assign w_rd_ok = rst_n && rd_req_valid && !w_hazard &&
                     (!r_rsp_pend || (w_rd_bank == w_last_bank));

    // Arbitration: a full FIFO gives the write priority, otherwise the read
    // wins. The loser may still issue when it targets a different bank.
    always_comb begin
        w_rd_issue = 1'b0;
        w_wr_issue = 1'b0;
        if (w_full) begin
            w_wr_issue = 1'b1;
            w_rd_issue = w_rd_ok && (w_rd_bank != w_head_bank);
        end else begin
            w_rd_issue = w_rd_ok;
            w_wr_issue = !w_empty && (!w_rd_ok || (w_head_bank != w_rd_bank));
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign rd_req_ready = w_rd_issue;
    assign wr_req_ready = !w_full;

    // With no issue the last read address is held so the router keeps the
    // responding bank selected on its data mux.
    assign rp_en        = w_rd_issue;
    assign rp_addr      = w_rd_issue ? rd_req_addr : r_last_rd_addr;

    assign rd_rsp_valid = r_rsp_pend;
    assign rd_rsp_data  = r_rsp_pend ? rp_rdata : '0;

    assign wp_en        = w_wr_issue;
    assign wp_we        = w_wr_issue;
    assign wp_addr      = w_wr_issue ? w_head_addr : '0;
    assign wp_wdata     = w_wr_issue ? w_head_data : '0;

    assign idle         = w_empty && !r_rsp_pend;

    // -------------------------------------------------------------------------
    // Sequential logic
    // -------------------------------------------------------------------------
    // Storage array carries no reset: occupancy is defined by pointers/count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= wr_req_addr;
            r_fifo_data[r_wr_ptr] <= wr_req_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_rsp_pend     <= 1'b0;
            r_last_rd_addr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            r_rsp_pend <= w_rd_issue;
            if (w_rd_issue) begin
                r_last_rd_addr <= rd_req_addr;
            end
        end
    end

endmodule
